// File: rtl/divisor_pipe_flow.sv
// Fully pipelined restoring divider: input stage, WIDTH iteration stages, output stage.
// Optional Div0 result flag is enabled by defining DIVISOR_DIVZERO_FLAG_EN.
module divisor_pipe_flow #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4
) (
   input  logic             CLK,
   input  logic             RSTa,
   input  logic             Start,
   output logic             Ready,
   input  logic             Signed,
   input  logic [WIDTH-1:0] Num,
   input  logic [WIDTH-1:0] Den,
   input  logic [TAG_W-1:0] Tag,
   output logic             Done,
   input  logic             Ack,
   output logic [WIDTH-1:0] Coc,
   output logic [WIDTH-1:0] Res,
`ifdef DIVISOR_DIVZERO_FLAG_EN
   output logic             Div0,
`endif
   output logic [TAG_W-1:0] Tag_out
);

   // Stage 0 is the input register, stages 1..WIDTH are the iteration registers.
   localparam int unsigned NStg = WIDTH + 1;

   logic             vld_q  [NStg];
   logic [TAG_W-1:0] tag_q  [NStg];
   logic             negq_q [NStg];
   logic             negr_q [NStg];
   logic             dz_q   [NStg];
   logic [WIDTH-1:0] rem_q  [NStg];
   logic [WIDTH-1:0] quo_q  [NStg];
   logic [WIDTH-1:0] den_q  [NStg];

   logic [WIDTH:0]   trial  [WIDTH];
   logic [WIDTH:0]   diff   [WIDTH];
   logic [WIDTH-1:0] rem_d  [WIDTH];
   logic [WIDTH-1:0] quo_d  [WIDTH];

   logic             done_q;
   logic [WIDTH-1:0] coc_q, coc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [TAG_W-1:0] tag_out_q;
`ifdef DIVISOR_DIVZERO_FLAG_EN
   logic             div0_q;
`endif

   logic             advance;
   logic             num_neg, den_neg, den_zero;
   logic [WIDTH-1:0] num_abs, den_abs;

   // Any unacknowledged result freezes every stage.
   assign advance = !(done_q && !Ack);
   assign Ready   = advance;

   assign num_neg  = Signed & Num[WIDTH-1];
   assign den_neg  = Signed & Den[WIDTH-1];
   assign den_zero = (Den == '0);
   assign num_abs  = num_neg ? -Num : Num;
   assign den_abs  = den_neg ? -Den : Den;

   // Partial remainder stays below the divisor, so no borrow means bit WIDTH of diff is clear.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         trial[i] = {rem_q[i], quo_q[i][WIDTH-1]};
         diff[i]  = trial[i] - {1'b0, den_q[i]};
         if (!diff[i][WIDTH]) begin
            rem_d[i] = diff[i][WIDTH-1:0];
            quo_d[i] = {quo_q[i][WIDTH-2:0], 1'b1};
         end else begin
            rem_d[i] = trial[i][WIDTH-1:0];
            quo_d[i] = {quo_q[i][WIDTH-2:0], 1'b0};
         end
      end
   end

   // With Den=0 the iterations leave |Num| in the remainder, so re-signing it restores Num.
   always_comb begin
      coc_d = negq_q[WIDTH] ? -quo_q[WIDTH] : quo_q[WIDTH];
      if (dz_q[WIDTH]) begin
         coc_d = '1;
      end
      res_d = negr_q[WIDTH] ? -rem_q[WIDTH] : rem_q[WIDTH];
   end

   always_ff @(posedge CLK) begin
      if (RSTa) begin
         for (int i = 0; i < NStg; i++) begin
            vld_q[i]  <= 1'b0;
            tag_q[i]  <= '0;
            negq_q[i] <= 1'b0;
            negr_q[i] <= 1'b0;
            dz_q[i]   <= 1'b0;
            rem_q[i]  <= '0;
            quo_q[i]  <= '0;
            den_q[i]  <= '0;
         end
         done_q    <= 1'b0;
         coc_q     <= '0;
         res_q     <= '0;
         tag_out_q <= '0;
`ifdef DIVISOR_DIVZERO_FLAG_EN
         div0_q    <= 1'b0;
`endif
      end else if (advance) begin
         vld_q[0] <= Start;
         if (Start) begin
            tag_q[0]  <= Tag;
            negq_q[0] <= (num_neg ^ den_neg) & ~den_zero;
            negr_q[0] <= num_neg;
            dz_q[0]   <= den_zero;
            rem_q[0]  <= '0;
            quo_q[0]  <= num_abs;
            den_q[0]  <= den_abs;
         end
         for (int i = 0; i < WIDTH; i++) begin
            vld_q[i+1]  <= vld_q[i];
            tag_q[i+1]  <= tag_q[i];
            negq_q[i+1] <= negq_q[i];
            negr_q[i+1] <= negr_q[i];
            dz_q[i+1]   <= dz_q[i];
            rem_q[i+1]  <= rem_d[i];
            quo_q[i+1]  <= quo_d[i];
            den_q[i+1]  <= den_q[i];
         end
         done_q <= vld_q[WIDTH];
         if (vld_q[WIDTH]) begin
            coc_q     <= coc_d;
            res_q     <= res_d;
            tag_out_q <= tag_q[WIDTH];
`ifdef DIVISOR_DIVZERO_FLAG_EN
            div0_q    <= dz_q[WIDTH];
`endif
         end
      end
   end

   assign Done    = done_q;
   assign Coc     = coc_q;
   assign Res     = res_q;
   assign Tag_out = tag_out_q;
`ifdef DIVISOR_DIVZERO_FLAG_EN
   assign Div0    = div0_q;
`endif

endmodule

// File: tb/tb_divisor_pipe_flow.sv
// Scoreboard bench for divisor_pipe_flow at WIDTH=8, TAG_W=4.
module tb_divisor_pipe_flow;

   localparam int W   = 8;
   localparam int TW  = 4;
   localparam int LAT = W + 2;

   logic          clk = 1'b0;
   logic          rsta, start, ready, sgn, done, ack;
   logic [W-1:0]  num, den, coc, res;
   logic [TW-1:0] tag, tag_out;
`ifdef DIVISOR_DIVZERO_FLAG_EN
   logic          div0;
`endif

   typedef struct {
      logic [W-1:0]  coc;
      logic [W-1:0]  res;
      logic [TW-1:0] tag;
      logic          dz;
      int            acc;
      bit            chk_lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   divisor_pipe_flow #(.WIDTH(W), .TAG_W(TW)) dut (
      .CLK     (clk),
      .RSTa    (rsta),
      .Start   (start),
      .Ready   (ready),
      .Signed  (sgn),
      .Num     (num),
      .Den     (den),
      .Tag     (tag),
      .Done    (done),
      .Ack     (ack),
      .Coc     (coc),
      .Res     (res),
`ifdef DIVISOR_DIVZERO_FLAG_EN
      .Div0    (div0),
`endif
      .Tag_out (tag_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void model(input logic s, input logic [W-1:0] n, input logic [W-1:0] d,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      int sn, sd, iq, ir;
      if (d == 0) begin
         q = '1;
         r = n;
      end else if (s && n == 8'h80 && d == 8'hFF) begin
         q = 8'h80;
         r = 8'h00;
      end else if (s) begin
         sn = int'($signed(n));
         sd = int'($signed(d));
         iq = sn / sd;
         ir = sn % sd;
         q  = iq[W-1:0];
         r  = ir[W-1:0];
      end else begin
         q = n / d;
         r = n % d;
      end
   endfunction

   // One cycle of stimulus; an accepted op pushes its expected result.
   task automatic drive(input logic st, input logic ak, input logic sg, input logic [W-1:0] n,
                        input logic [W-1:0] d, input logic [TW-1:0] tg, input bit lat);
      exp_t e;
      @(posedge clk);
      #1;
      start = st;
      ack   = ak;
      sgn   = sg;
      num   = n;
      den   = d;
      tag   = tg;
      #1;
      if (st && ready && !rsta) begin
         model(sg, n, d, e.coc, e.res);
         e.tag     = tg;
         e.dz      = (d == 0);
         e.acc     = cyc;
         e.chk_lat = lat;
         sb.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (!rsta && done && ack) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL spurious_done got coc=%h res=%h tag=%0d, required no Done", coc, res,
                     tag_out);
         end else begin
            e = sb.pop_front();
            if ({coc, res, tag_out} !== {e.coc, e.res, e.tag}) begin
               $display("FAIL result got coc=%h res=%h tag=%0d, required coc=%h res=%h tag=%0d",
                        coc, res, tag_out, e.coc, e.res, e.tag);
            end else begin
               n_pass++;
            end
            if (e.chk_lat) begin
               lat = cyc - e.acc;
               n_checks++;
               if (lat !== LAT) begin
                  $display("FAIL latency tag=%0d got %0d, required %0d", e.tag, lat, LAT);
               end else begin
                  n_pass++;
               end
            end
`ifdef DIVISOR_DIVZERO_FLAG_EN
            n_checks++;
            if (div0 !== e.dz) begin
               $display("FAIL div0 tag=%0d got %b, required %b", e.tag, div0, e.dz);
            end else begin
               n_pass++;
            end
`endif
         end
      end
   end

   task automatic drain(input logic [TW-1:0] marker);
      for (int k = 0; k < 40 && sb.size() != 0; k++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
      n_checks++;
      if (sb.size() != 0) begin
         $display("FAIL drain_%0d got %0d pending, required 0", marker, sb.size());
      end else begin
         n_pass++;
      end
   endtask

   task automatic test_reset;
      rsta = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rsta = 1'b0;
      #1;
      n_checks += 5;
      if (done !== 1'b0) $display("FAIL reset_done got %b, required 0", done);
      else n_pass++;
      if (coc !== 8'h00) $display("FAIL reset_coc got %h, required 00", coc);
      else n_pass++;
      if (res !== 8'h00) $display("FAIL reset_res got %h, required 00", res);
      else n_pass++;
      if (tag_out !== 4'h0) $display("FAIL reset_tag got %h, required 0", tag_out);
      else n_pass++;
      if (ready !== 1'b1) $display("FAIL reset_ready got %b, required 1", ready);
      else n_pass++;
   endtask

   task automatic test_directed;
      drive(1'b1, 1'b1, 1'b0, 8'd200, 8'd3, 4'd5, 1'b1);
      drain(4'd1);
      drive(1'b1, 1'b1, 1'b1, 8'hF9, 8'h02, 4'd6, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 8'd100, 8'hF9, 4'd7, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 4'd8, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 8'hFB, 8'h00, 4'd9, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 8'h80, 8'hFF, 4'd10, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 4'd11, 1'b1);
      drain(4'd2);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'(i), 1'b1);
      end
      drain(4'd3);
   endtask

   task automatic test_stall;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'(i), 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'hAA, 8'h07, 4'hF, 1'b0);
         n_checks += 5;
         if (ready !== 1'b0) $display("FAIL stall_ready got %b, required 0", ready);
         else n_pass++;
         if (done !== 1'b1) $display("FAIL stall_done got %b, required 1", done);
         else n_pass++;
         if (coc !== sb[0].coc) $display("FAIL stall_coc got %h, required %h", coc, sb[0].coc);
         else n_pass++;
         if (res !== sb[0].res) $display("FAIL stall_res got %h, required %h", res, sb[0].res);
         else n_pass++;
         if (tag_out !== sb[0].tag) begin
            $display("FAIL stall_tag got %h, required %h", tag_out, sb[0].tag);
         end else begin
            n_pass++;
         end
      end
      for (int i = 12; i < 15; i++) begin
         drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'(i), 1'b0);
      end
      drain(4'd4);
   endtask

   task automatic test_reset_mid;
      int n_done = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 8'd250 - 8'(i), 8'd3, 4'(i + 1), 1'b0);
      end
      @(posedge clk);
      #1;
      rsta  = 1'b1;
      start = 1'b1;
      num   = 8'd99;
      den   = 8'd4;
      tag   = 4'hC;
      sb.delete();
      @(posedge clk);
      #1;
      rsta  = 1'b0;
      start = 1'b0;
      #1;
      n_checks += 5;
      if (done !== 1'b0) $display("FAIL midrst_done got %b, required 0", done);
      else n_pass++;
      if (coc !== 8'h00) $display("FAIL midrst_coc got %h, required 00", coc);
      else n_pass++;
      if (res !== 8'h00) $display("FAIL midrst_res got %h, required 00", res);
      else n_pass++;
      if (tag_out !== 4'h0) $display("FAIL midrst_tag got %h, required 0", tag_out);
      else n_pass++;
      if (ready !== 1'b1) $display("FAIL midrst_ready got %b, required 1", ready);
      else n_pass++;
      for (int k = 0; k < LAT + 6; k++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
         if (done) n_done++;
      end
      n_checks++;
      if (n_done != 0) $display("FAIL midrst_no_done got %0d Done cycles, required 0", n_done);
      else n_pass++;
   endtask

   initial begin
      rsta  = 1'b1;
      start = 1'b0;
      ack   = 1'b1;
      sgn   = 1'b0;
      num   = '0;
      den   = '0;
      tag   = '0;
      test_reset;
      test_directed;
      test_back_to_back;
      test_stall;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/divisor_pipe_flow.md
DIVISOR_PIPE_FLOW -- requirements
Module: divisor_pipe_flow

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >=4).
REQ-002 SHALL have parameter TAG_W, default 4, width of the user tag carried alongside each operation.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTa  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port Start  input  1  operation request valid.
REQ-006 SHALL have port Ready  output  1  block accepts Start this cycle.
REQ-007 SHALL have port Signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port Num  input  WIDTH  dividend.
REQ-009 SHALL have port Den  input  WIDTH  divisor.
REQ-010 SHALL have port Tag  input  TAG_W  user tag, returned unchanged with the result.
REQ-011 SHALL have port Done  output  1  result valid.
REQ-012 SHALL have port Ack  input  1  downstream accepts result.
REQ-013 SHALL have port Coc  output  WIDTH  quotient.
REQ-014 SHALL have port Res  output  WIDTH  remainder.
REQ-015 SHALL have port Tag_out  output  TAG_W  tag of the operation on Coc/Res.

Function
REQ-016 SHALL be a fully pipelined restoring divider: 1 input stage (sign capture, absolute values), WIDTH iteration stages (each does shift and conditional subtract, producing one quotient bit), 1 output stage (sign correction, special cases).
REQ-017 SHALL accept an operation when Start=1 and Ready=1 in the same cycle.
REQ-018 SHALL, with no stall, assert Done for that operation exactly WIDTH+2 cycles after acceptance.
REQ-019 SHALL sustain one accepted operation per cycle; results emerge in acceptance order.
REQ-020 SHALL propagate a per-stage valid bit; empty stages carry no result and never raise Done.
REQ-021 SHALL stall the whole pipeline (no stage register changes) while Done=1 and Ack=0.
REQ-022 SHALL drive Ready = !(Done && !Ack); Start while Ready=0 is ignored and operands are dropped.
REQ-023 SHALL hold Coc, Res, Tag_out and Done stable while stalled.
REQ-024 SHALL, in signed mode, truncate the quotient toward zero; remainder takes the dividend's sign.
REQ-025 SHALL, for Den=0, output Coc = all ones, Res = Num, independent of Signed.
REQ-026 SHALL, for Signed=1, Num = most-negative and Den = all ones, output Coc = Num, Res = 0.
REQ-027 SHALL treat absolute values as WIDTH-bit unsigned (most-negative magnitude 2^(WIDTH-1)), no extra sign bit in the iteration stages.
REQ-028 SHALL let Start with Ack=1 and Done=1 in the same cycle advance the pipeline and accept the new operation.

Reset
REQ-029 SHALL, when RSTa=1 at a rising edge, clear all valid bits and data/tag registers to 0.
REQ-030 SHALL, after reset, drive Done=0, Coc=0, Res=0, Tag_out=0, Ready=1.
REQ-031 SHALL discard all in-flight operations on reset mid-operation; none produces Done afterwards.
REQ-032 SHALL ignore Start during a cycle with RSTa=1.

Configuration
REQ-033 SHALL, with macro DIVISOR_DIVZERO_FLAG_EN defined, add output port Div0 (1 bit): 1 together with Done when the result came from Den=0, held while stalled, reset 0.
REQ-034 SHALL, without DIVISOR_DIVZERO_FLAG_EN, omit Div0 and its pipeline bit; all other behaviour is identical.

Verification (WIDTH=8, TAG_W=4)
REQ-035 SHALL cover: unsigned Num=200, Den=3, Tag=5 -> Done at +10 cycles, Coc=66, Res=2, Tag_out=5.
REQ-036 SHALL cover: signed Num=-7 (0xF9), Den=2 -> Coc=0xFD (-3), Res=0xFF (-1); Num=100, Den=-7 -> Coc=0xF2 (-14), Res=2.
REQ-037 SHALL cover: Num=5, Den=0 -> Coc=0xFF, Res=0x05 (Div0=1 when macro enabled); signed 0x80 / 0xFF -> Coc=0x80, Res=0x00.
REQ-038 SHALL cover: 12 back-to-back ops, Ack=1 -> 12 consecutive Done cycles, results in order, correct tags.
REQ-039 SHALL cover: Ack=0 for 5 cycles with Done=1 -> Ready=0, outputs frozen, Start ignored; Ack=1 -> stream resumes with no loss or duplication.
REQ-040 SHALL cover: RSTa=1 for one cycle with 4 ops in flight -> no Done afterwards; outputs 0 and Ready=1 next cycle.
